// File: rtl/iob_axi_slave_pkg.sv
// iob_axi_slave_pkg: shared types and codes for the AXI-to-native slave.
// Holds FSM state encoding, AXI response codes and burst type codes.
package iob_axi_slave_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_MEM  = 3'd1;
  localparam logic [2:0] ST_RD_RESP = 3'd2;
  localparam logic [2:0] ST_WR_DATA = 3'd3;
  localparam logic [2:0] ST_WR_MEM  = 3'd4;
  localparam logic [2:0] ST_WR_RESP = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    RD_MEM  = ST_RD_MEM,
    RD_RESP = ST_RD_RESP,
    WR_DATA = ST_WR_DATA,
    WR_MEM  = ST_WR_MEM,
    WR_RESP = ST_WR_RESP
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

endpackage

// File: rtl/iob_axi_burst_ctr.sv
// iob_axi_burst_ctr: burst address / beat counter shared by read and write.
// Ports: load_i+addr_i/len_i/burst_i start a burst, step_i advances one
// beat; cur_addr_o is the aligned beat address, last_o flags the final beat.
module iob_axi_burst_ctr
  import iob_axi_slave_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NBYTES = 4,
  parameter int BYTE_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [7:0]        len_i,
  input  logic [1:0]        burst_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] cur_addr_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] INC = ADDR_W'(NBYTES);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        burst_q, burst_d;

  always_comb begin
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    if (load_i) begin
      addr_d  = {addr_i[ADDR_W-1:BYTE_W], {BYTE_W{1'b0}}};
      len_d   = len_i;
      cnt_d   = '0;
      burst_d = burst_i;
    end else if (step_i) begin
      cnt_d = cnt_q + 8'd1;
      // WRAP and the reserved code both walk upward like INCR
      if (burst_q != AXI_BURST_FIXED)
        addr_d = addr_q + INC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= AXI_BURST_FIXED;
    end else begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
    end
  end

  assign cur_addr_o = addr_q;
  assign last_o     = (cnt_q == len_q);

endmodule

// File: rtl/iob_axi_slave_native.sv
// iob_axi_slave_native: AXI4 burst slave bridged to single-beat native iob.
// Ports: AXI AW/W/B/AR/R channels (axi_*), native mem_* request/response.
module iob_axi_slave_native
  import iob_axi_slave_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int AXI_ID_W = 1,
  parameter int NBYTES   = DATA_W / 8,
  parameter int BYTE_W   = $clog2(NBYTES)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [7:0]          axi_awlen,
  input  logic [1:0]          axi_awburst,
  input  logic [AXI_ID_W-1:0] axi_awid,
  input  logic                axi_wvalid,
  output logic                axi_wready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [NBYTES-1:0]   axi_wstrb,
  input  logic                axi_wlast,
  output logic                axi_bvalid,
  input  logic                axi_bready,
  output logic [1:0]          axi_bresp,
  output logic [AXI_ID_W-1:0] axi_bid,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [7:0]          axi_arlen,
  input  logic [1:0]          axi_arburst,
  input  logic [AXI_ID_W-1:0] axi_arid,
  output logic                axi_rvalid,
  input  logic                axi_rready,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [1:0]          axi_rresp,
  output logic                axi_rlast,
  output logic [AXI_ID_W-1:0] axi_rid,
  output logic                mem_valid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [NBYTES-1:0]   mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  state_t              state_q, state_d;
  logic                last_wr_q, last_wr_d;
  logic                err_q, err_d;
  logic [AXI_ID_W-1:0] id_q, id_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NBYTES-1:0]   wstrb_q, wstrb_d;

  logic                aw_sel, ar_sel;
  logic                aw_acc, ar_acc;
  logic                ctr_load, ctr_step;
  logic [ADDR_W-1:0]   ld_addr;
  logic [7:0]          ld_len;
  logic [1:0]          ld_burst;
  logic [ADDR_W-1:0]   cur_addr;
  logic                last;

  // On a tie, serve the direction not served last time
  assign aw_sel = axi_awvalid & (~axi_arvalid | ~last_wr_q);
  assign ar_sel = axi_arvalid & ~aw_sel;

  // reset gating keeps the combinational readies low while in reset
  assign aw_acc = reset & (state_q == IDLE) & aw_sel;
  assign ar_acc = reset & (state_q == IDLE) & ar_sel;

  assign ld_addr  = aw_sel ? axi_awaddr  : axi_araddr;
  assign ld_len   = aw_sel ? axi_awlen   : axi_arlen;
  assign ld_burst = aw_sel ? axi_awburst : axi_arburst;

  iob_axi_burst_ctr #(
    .ADDR_W (ADDR_W),
    .NBYTES (NBYTES),
    .BYTE_W (BYTE_W)
  ) u_ctr (
    .clk        (clk),
    .rst_n      (reset),
    .load_i     (ctr_load),
    .addr_i     (ld_addr),
    .len_i      (ld_len),
    .burst_i    (ld_burst),
    .step_i     (ctr_step),
    .cur_addr_o (cur_addr),
    .last_o     (last)
  );

  always_comb begin
    state_d   = state_q;
    last_wr_d = last_wr_q;
    err_d     = err_q;
    id_d      = id_q;
    rdata_d   = rdata_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    ctr_load  = 1'b0;
    ctr_step  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (aw_acc) begin
          ctr_load  = 1'b1;
          id_d      = axi_awid;
          last_wr_d = 1'b1;
          err_d     = 1'b0;
          state_d   = WR_DATA;
        end else if (ar_acc) begin
          ctr_load  = 1'b1;
          id_d      = axi_arid;
          last_wr_d = 1'b0;
          state_d   = RD_MEM;
        end
      end
      RD_MEM: begin
        if (mem_ready) begin
          rdata_d = mem_rdata;
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        if (axi_rready) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            ctr_step = 1'b1;
            state_d  = RD_MEM;
          end
        end
      end
      WR_DATA: begin
        if (axi_wvalid) begin
          wdata_d = axi_wdata;
          wstrb_d = axi_wstrb;
          if (axi_wlast != last)
            err_d = 1'b1;
          // A beat with no enabled bytes never reaches memory
          if (axi_wstrb == '0) begin
            if (last) begin
              state_d = WR_RESP;
            end else begin
              ctr_step = 1'b1;
            end
          end else begin
            state_d = WR_MEM;
          end
        end
      end
      WR_MEM: begin
        if (mem_ready) begin
          if (last) begin
            state_d = WR_RESP;
          end else begin
            ctr_step = 1'b1;
            state_d  = WR_DATA;
          end
        end
      end
      WR_RESP: begin
        if (axi_bready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_wr_q <= 1'b0;
      err_q     <= 1'b0;
      id_q      <= '0;
      rdata_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_wr_q <= last_wr_d;
      err_q     <= err_d;
      id_q      <= id_d;
      rdata_q   <= rdata_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign axi_awready = aw_acc;
  assign axi_arready = ar_acc;
  assign axi_wready  = (state_q == WR_DATA);
  assign axi_bvalid  = (state_q == WR_RESP);
  assign axi_bresp   = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign axi_bid     = id_q;
  assign axi_rvalid  = (state_q == RD_RESP);
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = AXI_RESP_OKAY;
  assign axi_rlast   = (state_q == RD_RESP) & last;
  assign axi_rid     = id_q;

  assign mem_valid = (state_q == RD_MEM) | (state_q == WR_MEM);
  assign mem_addr  = mem_valid ? cur_addr : '0;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = (state_q == WR_MEM) ? wstrb_q : '0;

endmodule

// File: tb/tb_iob_axi_slave_native.sv
// tb_iob_axi_slave_native: directed table-driven bench for the AXI slave.
// A native memory model answers requests; logs are checked per transaction.
module tb_iob_axi_slave_native;

  logic        clk;
  logic        rst_n;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [1:0]  awburst;
  logic        awid;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        bid;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [1:0]  arburst;
  logic        arid;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rid;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  iob_axi_slave_native dut (
    .clk         (clk),
    .reset       (rst_n),
    .axi_awvalid (awvalid),
    .axi_awready (awready),
    .axi_awaddr  (awaddr),
    .axi_awlen   (awlen),
    .axi_awburst (awburst),
    .axi_awid    (awid),
    .axi_wvalid  (wvalid),
    .axi_wready  (wready),
    .axi_wdata   (wdata),
    .axi_wstrb   (wstrb),
    .axi_wlast   (wlast),
    .axi_bvalid  (bvalid),
    .axi_bready  (bready),
    .axi_bresp   (bresp),
    .axi_bid     (bid),
    .axi_arvalid (arvalid),
    .axi_arready (arready),
    .axi_araddr  (araddr),
    .axi_arlen   (arlen),
    .axi_arburst (arburst),
    .axi_arid    (arid),
    .axi_rvalid  (rvalid),
    .axi_rready  (rready),
    .axi_rdata   (rdata),
    .axi_rresp   (rresp),
    .axi_rlast   (rlast),
    .axi_rid     (rid),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic        id;
    logic [3:0]  strb;
    int          wlast_at;
    int          mdly;
    bit          rtog;
    logic [31:0] exp_a0;
    logic [31:0] exp_inc;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } mem_t;

  typedef struct {
    logic [31:0] d;
    logic        last;
    logic        id;
    logic [1:0]  resp;
  } r_t;

  typedef struct {
    logic [1:0] resp;
    logic       id;
  } b_t;

  mem_t mem_log[$];
  r_t   r_log[$];
  b_t   b_log[$];

  int n_chk  = 0;
  int n_fail = 0;
  int mem_dly = 0;
  int wait_cnt = 0;
  int stab_err = 0;
  bit rtog = 0;
  bit r_hold = 0;
  bit prev_hold = 0;
  logic [31:0] prev_d = '0;

  vec_t vecs[10];
  vec_t rec_v;

  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hA5A5A5A5 : ((a ^ 32'h5A5A0000) + 32'h1);
  endfunction

  function automatic logic [31:0] wd_fn(input int idx, input int b);
    return 32'hD0000000 | (32'(idx) << 8) | 32'(b);
  endfunction

  task automatic check(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Native memory model: answers after mem_dly idle cycles
  always @(negedge clk) begin
    if (mem_valid && !mem_ready && wait_cnt >= mem_dly) begin
      mem_ready = 1'b1;
      mem_rdata = rd_fn(mem_addr);
      wait_cnt  = 0;
    end else begin
      if (mem_valid && !mem_ready) wait_cnt++;
      else wait_cnt = 0;
      mem_ready = 1'b0;
      mem_rdata = 32'hDEADBEEF;
    end
  end

  always @(negedge clk) begin
    if (r_hold) rready = 1'b0;
    else if (rtog) rready = ~rready;
    else rready = 1'b1;
  end

  always @(posedge clk) begin
    if (mem_valid && mem_ready)
      mem_log.push_back('{a: mem_addr, d: mem_wdata, s: mem_wstrb});
    if (rvalid && rready)
      r_log.push_back('{d: rdata, last: rlast, id: rid, resp: rresp});
    if (bvalid && bready)
      b_log.push_back('{resp: bresp, id: bid});
    if (prev_hold && rvalid && rdata !== prev_d) stab_err++;
    prev_hold = rvalid && !rready;
    prev_d    = rdata;
  end

  task automatic send_aw(input logic [31:0] a, input logic [7:0] l,
                         input logic [1:0] bt, input logic id, input string nm);
    bit ok;
    ok = 0;
    @(negedge clk);
    awvalid = 1; awaddr = a; awlen = l; awburst = bt; awid = id;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      if (awready) begin ok = 1; break; end
    end
    @(negedge clk);
    awvalid = 0;
    check({nm, "_aw_hs"}, 128'(ok), 128'(1));
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] l,
                         input logic [1:0] bt, input logic id, input string nm);
    bit ok;
    ok = 0;
    @(negedge clk);
    arvalid = 1; araddr = a; arlen = l; arburst = bt; arid = id;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      if (arready) begin ok = 1; break; end
    end
    @(negedge clk);
    arvalid = 0;
    check({nm, "_ar_hs"}, 128'(ok), 128'(1));
  endtask

  task automatic send_w(input int len, input logic [3:0] s, input int wl,
                        input int idx, input string nm);
    bit ok;
    ok = 1;
    for (int b = 0; b <= len; b++) begin
      bit got;
      got = 0;
      @(negedge clk);
      wvalid = 1; wdata = wd_fn(idx, b); wstrb = s; wlast = (b == wl);
      for (int t = 0; t < 100; t++) begin
        @(posedge clk);
        if (wready) begin got = 1; break; end
      end
      if (!got) ok = 0;
    end
    @(negedge clk);
    wvalid = 0; wlast = 0;
    check({nm, "_w_hs"}, 128'(ok), 128'(1));
  endtask

  task automatic wait_b(input string nm);
    for (int t = 0; t < 300; t++) begin
      @(posedge clk);
      if (b_log.size() > 0) break;
    end
    repeat (3) @(posedge clk);
    check({nm, "_nb"}, 128'(b_log.size()), 128'(1));
  endtask

  task automatic wait_r(input int n, input string nm);
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk);
      if (r_log.size() >= n) break;
    end
    repeat (3) @(posedge clk);
    check({nm, "_nr"}, 128'(r_log.size()), 128'(n));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string nm;
    int nexp;
    logic [31:0] ea;
    nm = $sformatf("v%0d", idx);
    mem_log.delete(); r_log.delete(); b_log.delete();
    stab_err = 0;
    mem_dly = v.mdly;
    rtog = v.rtog;
    if (v.wr) begin
      send_aw(v.addr, v.len, v.burst, v.id, nm);
      send_w(int'(v.len), v.strb, v.wlast_at, idx, nm);
      wait_b(nm);
      nexp = (v.strb == 4'h0) ? 0 : int'(v.len) + 1;
      check({nm, "_nmem"}, 128'(mem_log.size()), 128'(nexp));
      for (int b = 0; b < nexp && b < mem_log.size(); b++) begin
        ea = v.exp_a0 + 32'(b) * v.exp_inc;
        check($sformatf("%s_wr%0d", nm, b),
              {mem_log[b].a, mem_log[b].d, mem_log[b].s},
              {ea, wd_fn(idx, b), v.strb});
      end
      if (b_log.size() > 0)
        check({nm, "_bresp_bid"}, {b_log[0].resp, b_log[0].id},
              {v.exp_resp, v.id});
    end else begin
      send_ar(v.addr, v.len, v.burst, v.id, nm);
      wait_r(int'(v.len) + 1, nm);
      nexp = int'(v.len) + 1;
      check({nm, "_nmem"}, 128'(mem_log.size()), 128'(nexp));
      for (int b = 0; b < nexp && b < mem_log.size(); b++) begin
        ea = v.exp_a0 + 32'(b) * v.exp_inc;
        check($sformatf("%s_rdaddr%0d", nm, b),
              {mem_log[b].a, mem_log[b].s}, {ea, 4'h0});
      end
      for (int b = 0; b < nexp && b < r_log.size(); b++) begin
        ea = v.exp_a0 + 32'(b) * v.exp_inc;
        check($sformatf("%s_rbeat%0d", nm, b),
              {r_log[b].d, r_log[b].last, r_log[b].id, r_log[b].resp},
              {rd_fn(ea), (b == nexp - 1), v.id, 2'b00});
      end
      check({nm, "_rstable"}, 128'(stab_err), 128'(0));
    end
    rtog = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int lat;
    bit ok;

    vecs[0] = '{wr:0, addr:32'h100, len:0, burst:2'b01, id:1, strb:0,
                wlast_at:0, mdly:0, rtog:0, exp_a0:32'h100, exp_inc:4,
                exp_resp:2'b00};
    vecs[1] = '{wr:1, addr:32'h203, len:3, burst:2'b01, id:1, strb:4'hF,
                wlast_at:3, mdly:0, rtog:0, exp_a0:32'h200, exp_inc:4,
                exp_resp:2'b00};
    vecs[2] = '{wr:0, addr:32'h300, len:7, burst:2'b01, id:0, strb:0,
                wlast_at:0, mdly:3, rtog:1, exp_a0:32'h300, exp_inc:4,
                exp_resp:2'b00};
    vecs[3] = '{wr:1, addr:32'h400, len:3, burst:2'b01, id:0, strb:4'hF,
                wlast_at:1, mdly:1, rtog:0, exp_a0:32'h400, exp_inc:4,
                exp_resp:2'b10};
    vecs[4] = '{wr:1, addr:32'h500, len:2, burst:2'b00, id:1, strb:4'h5,
                wlast_at:2, mdly:0, rtog:0, exp_a0:32'h500, exp_inc:0,
                exp_resp:2'b00};
    vecs[5] = '{wr:0, addr:32'hFFFFFFFC, len:1, burst:2'b01, id:1, strb:0,
                wlast_at:0, mdly:0, rtog:0, exp_a0:32'hFFFFFFFC, exp_inc:4,
                exp_resp:2'b00};
    vecs[6] = '{wr:0, addr:32'h602, len:2, burst:2'b00, id:0, strb:0,
                wlast_at:0, mdly:2, rtog:0, exp_a0:32'h600, exp_inc:0,
                exp_resp:2'b00};
    vecs[7] = '{wr:1, addr:32'h700, len:2, burst:2'b10, id:0, strb:4'hC,
                wlast_at:2, mdly:0, rtog:0, exp_a0:32'h700, exp_inc:4,
                exp_resp:2'b00};
    vecs[8] = '{wr:1, addr:32'h800, len:1, burst:2'b01, id:1, strb:4'h0,
                wlast_at:1, mdly:0, rtog:0, exp_a0:32'h800, exp_inc:4,
                exp_resp:2'b00};
    vecs[9] = '{wr:0, addr:32'h900, len:1, burst:2'b11, id:0, strb:0,
                wlast_at:0, mdly:1, rtog:1, exp_a0:32'h900, exp_inc:4,
                exp_resp:2'b00};
    rec_v   = '{wr:0, addr:32'h2000, len:1, burst:2'b01, id:0, strb:0,
                wlast_at:0, mdly:0, rtog:0, exp_a0:32'h2000, exp_inc:4,
                exp_resp:2'b00};

    rst_n = 0;
    awvalid = 0; awaddr = 0; awlen = 0; awburst = 0; awid = 0;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 1;
    arvalid = 0; araddr = 0; arlen = 0; arburst = 0; arid = 0;
    rready = 0; mem_ready = 0; mem_rdata = 0;
    repeat (3) @(negedge clk);
    check("reset_ctrl",
          {awready, arready, wready, bvalid, rvalid, rlast, mem_valid}, 0);
    check("reset_data",
          {rdata, mem_addr, mem_wdata, mem_wstrb, rid, bid, rresp, bresp}, 0);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // both channels request right after reset: write is served first
    mem_log.delete(); b_log.delete(); r_log.delete();
    awvalid = 1; awaddr = 32'h40; awlen = 0; awburst = 2'b01; awid = 1;
    arvalid = 1; araddr = 32'h80; arlen = 0; arburst = 2'b01; arid = 0;
    @(posedge clk);
    check("arb1_sel", {awready, arready}, 2'b10);
    @(negedge clk);
    awvalid = 0; arvalid = 0;
    send_w(0, 4'hF, 0, 20, "arb1");
    wait_b("arb1");
    check("arb1_mem", 128'(mem_log.size() > 0 ? mem_log[0].a : 32'hFFFFFFFF),
          128'(32'h40));

    // both again: the read now wins, first rvalid two cycles later
    mem_log.delete(); r_log.delete();
    @(negedge clk);
    awvalid = 1; awaddr = 32'h44; awlen = 0; awburst = 2'b01; awid = 0;
    arvalid = 1; araddr = 32'h80; arlen = 0; arburst = 2'b01; arid = 1;
    @(posedge clk);
    check("arb2_sel", {awready, arready}, 2'b01);
    @(negedge clk);
    awvalid = 0; arvalid = 0;
    lat = 0;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk);
      if (rvalid) begin lat = t; break; end
    end
    check("arb2_rd_latency", 128'(lat), 128'(2));
    wait_r(1, "arb2");
    if (r_log.size() > 0)
      check("arb2_rbeat", {r_log[0].d, r_log[0].last, r_log[0].id},
            {rd_fn(32'h80), 1'b1, 1'b1});

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
      repeat (2) @(negedge clk);
    end

    // reset while a read beat is waiting for rready
    mem_log.delete(); r_log.delete();
    r_hold = 1;
    mem_dly = 0;
    send_ar(32'h1000, 3, 2'b01, 1, "rstmid");
    ok = 0;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk);
      if (rvalid) begin ok = 1; break; end
    end
    check("rstmid_rvalid_seen", 128'(ok), 128'(1));
    @(negedge clk);
    rst_n = 0;
    #1;
    check("rstmid_ctrl",
          {awready, arready, wready, bvalid, rvalid, rlast, mem_valid}, 0);
    check("rstmid_data",
          {rdata, mem_addr, mem_wdata, mem_wstrb, rid, bid, rresp, bresp}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    r_hold = 0;
    repeat (2) @(negedge clk);
    run_vec(rec_v, 10);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
